instr_encode_loader: RTL and testbench

Encoder counterpart to the opcode-decoding control unit. It accepts instruction fields over a valid/ready handshake, assembles 32-bit MIPS words (R-type, lw, sw, beq), and writes them sequentially into instruction memory. It sits between the testbench/boot sequencer and the instruction memory, and fills the program that the datapath and control unit later fetch and decode.

---
 rtl/instr_encode_loader.sv | 137 +++++++++++++
 tb/tb_instr_encode_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encode_loader.sv
// Assembles MIPS instruction words (R-type, lw, sw, beq) from a field bundle and writes them
// sequentially into instruction memory, one word per three cycles.
module instr_encode_loader #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CLEAR,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [2:0]        OP_TYPE,
  input  logic [4:0]        RS,
  input  logic [4:0]        RT,
  input  logic [4:0]        RD,
  input  logic [4:0]        SHAMT,
  input  logic [5:0]        FUNCT,
  input  logic [15:0]       IMM,
  output logic              IMEM_WE,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  output logic [31:0]       IMEM_WDATA,
  output logic [ADDR_W:0]   COUNT,
  output logic              FULL,
  output logic              ERR
);

  typedef enum logic [1:0] {StIdle, StEnc, StWr} state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic [2:0]        r_op;
  logic [4:0]        r_rs;
  logic [4:0]        r_rt;
  logic [4:0]        r_rd;
  logic [4:0]        r_shamt;
  logic [5:0]        r_funct;
  logic [15:0]       r_imm;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [ADDR_W:0]   r_count;
  logic              r_err;
  logic              w_accept;
  logic              w_op_valid;
  logic [31:0]       w_word;

  assign IMEM_ADDR  = r_addr;
  assign IMEM_WDATA = r_wdata;
  assign COUNT      = r_count;
  assign ERR        = r_err;
  // COUNT never exceeds 2^ADDR_W, so its MSB alone marks capacity.
  assign FULL       = r_count[ADDR_W];

  always_comb begin
    w_word     = '0;
    w_op_valid = 1'b1;
    case (r_op)
      3'd0:    w_word = {6'b000000, r_rs, r_rt, r_rd, r_shamt, r_funct};
      3'd1:    w_word = {6'b100011, r_rs, r_rt, r_imm};
      3'd2:    w_word = {6'b101011, r_rs, r_rt, r_imm};
      3'd3:    w_word = {6'b000100, r_rs, r_rt, r_imm};
      default: w_op_valid = 1'b0;
    endcase
  end

  // CLEAR overrides the handshake and aborts any in-flight word, including the write strobe.
  always_comb begin
    w_state_next = r_state;
    IN_READY     = 1'b0;
    IMEM_WE      = 1'b0;
    w_accept     = 1'b0;
    if (CLEAR) begin
      w_state_next = StIdle;
    end else begin
      case (r_state)
        StIdle: begin
          IN_READY = !FULL;
          w_accept = IN_VALID && !FULL;
          if (w_accept) w_state_next = StEnc;
        end
        StEnc:   w_state_next = w_op_valid ? StWr : StIdle;
        StWr: begin
          IMEM_WE      = 1'b1;
          w_state_next = StIdle;
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_op    <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
      r_shamt <= '0;
      r_funct <= '0;
      r_imm   <= '0;
      r_ptr   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (CLEAR) begin
        r_ptr   <= '0;
        r_count <= '0;
        r_err   <= 1'b0;
      end else begin
        if (w_accept) begin
          r_op    <= OP_TYPE;
          r_rs    <= RS;
          r_rt    <= RT;
          r_rd    <= RD;
          r_shamt <= SHAMT;
          r_funct <= FUNCT;
          r_imm   <= IMM;
        end
        if (r_state == StEnc) begin
          if (w_op_valid) begin
            r_addr  <= r_ptr;
            r_wdata <= w_word;
          end else begin
            r_err <= 1'b1;
          end
        end
        if (r_state == StWr) begin
          r_ptr   <= r_ptr + ADDR_W'(1);
          r_count <= r_count + (ADDR_W + 1)'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader (ADDR_W = 2); expected writes are queued when a
// bundle is driven and compared when IMEM_WE fires.
module tb_instr_encode_loader;

  localparam int unsigned AW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          CLEAR = 1'b0;
  logic          IN_VALID = 1'b0;
  logic          IN_READY;
  logic [2:0]    OP_TYPE = '0;
  logic [4:0]    RS = '0, RT = '0, RD = '0, SHAMT = '0;
  logic [5:0]    FUNCT = '0;
  logic [15:0]   IMM = '0;
  logic          IMEM_WE;
  logic [AW-1:0] IMEM_ADDR;
  logic [31:0]   IMEM_WDATA;
  logic [AW:0]   COUNT;
  logic          FULL;
  logic          ERR;

  int errors = 0;
  int checks = 0;
  int writes = 0;
  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];

  instr_encode_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .CLEAR(CLEAR), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OP_TYPE(OP_TYPE), .RS(RS), .RT(RT), .RD(RD), .SHAMT(SHAMT), .FUNCT(FUNCT), .IMM(IMM),
    .IMEM_WE(IMEM_WE), .IMEM_ADDR(IMEM_ADDR), .IMEM_WDATA(IMEM_WDATA), .COUNT(COUNT),
    .FULL(FULL), .ERR(ERR)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (IMEM_WE === 1'b1) begin
      writes++;
      if (q_addr.size() == 0) begin
        check("unexpected_write", 32'(IMEM_ADDR), 32'hFFFF_FFFF);
      end else begin
        check("write_addr", 32'(IMEM_ADDR), q_addr.pop_front());
        check("write_data", IMEM_WDATA, q_data.pop_front());
      end
    end
  end

  // Returns #1 after the accepting edge, i.e. inside the ENC cycle.
  task automatic send(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                      input logic [15:0] imm, input bit push, input logic [31:0] addr,
                      input logic [31:0] word);
    if (push) begin
      q_addr.push_back(addr);
      q_data.push_back(word);
    end
    OP_TYPE = op; RS = rs; RT = rt; RD = rd; SHAMT = sh; FUNCT = fn; IMM = imm;
    IN_VALID = 1'b1;
    for (int i = 0; i < 100 && IN_READY !== 1'b1; i++) @(negedge clk);
    if (IN_READY !== 1'b1) check("accept_timeout", 32'(IN_READY), 32'd1);
    @(posedge clk);
    #1;
    IN_VALID = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int exp_lows);
    int lows = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (IN_READY === 1'b1) break;
      lows++;
    end
    check(tag, 32'(lows), 32'(exp_lows));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_we", 32'(IMEM_WE), 32'd0);
    check("rst_count", 32'(COUNT), 32'd0);
    check("rst_ready", 32'(IN_READY), 32'd1);
    check("rst_err", 32'(ERR), 32'd0);
    check("rst_full", 32'(FULL), 32'd0);
    check("rst_addr", 32'(IMEM_ADDR), 32'd0);
    check("rst_wdata", IMEM_WDATA, 32'd0);

    // R-type: strobe exactly two cycles after accept
    send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 1'b1, 32'd0, 32'h0022_1820);
    @(negedge clk);
    check("r_enc_we", 32'(IMEM_WE), 32'd0);
    check("r_enc_ready", 32'(IN_READY), 32'd0);
    @(negedge clk);
    check("r_wr_we", 32'(IMEM_WE), 32'd1);
    check("r_wr_count", 32'(COUNT), 32'd0);
    @(negedge clk);
    check("r_after_we", 32'(IMEM_WE), 32'd0);
    check("r_after_count", 32'(COUNT), 32'd1);
    check("r_after_ready", 32'(IN_READY), 32'd1);

    @(posedge clk); #1 CLEAR = 1'b1;
    @(posedge clk); #1 CLEAR = 1'b0;
    @(negedge clk);
    check("clr1_count", 32'(COUNT), 32'd0);

    // back-to-back I-type
    send(3'd1, 5'd9, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 1'b1, 32'd0, 32'h8D28_0004);
    wait_ready("lw_ready_low", 2);
    send(3'd2, 5'd9, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0008, 1'b1, 32'd1, 32'hAD28_0008);
    wait_ready("sw_ready_low", 2);
    send(3'd3, 5'd1, 5'd2, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 1'b1, 32'd2, 32'h1022_FFFF);
    wait_ready("beq_ready_low", 2);
    check("itype_count", 32'(COUNT), 32'd3);

    // invalid op: no write, ERR sticky, pointer unchanged
    send(3'd5, 5'd1, 5'd2, 5'd3, 5'd4, 6'd5, 16'h1234, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("inv_enc_err", 32'(ERR), 32'd0);
    check("inv_enc_ready", 32'(IN_READY), 32'd0);
    @(negedge clk);
    check("inv_err", 32'(ERR), 32'd1);
    check("inv_ready", 32'(IN_READY), 32'd1);
    check("inv_count", 32'(COUNT), 32'd3);
    send(3'd1, 5'd9, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 1'b1, 32'd3, 32'h8D28_0004);
    @(negedge clk);
    @(negedge clk);
    check("fill_wr_count", 32'(COUNT), 32'd3);
    check("fill_wr_full", 32'(FULL), 32'd0);
    @(negedge clk);
    check("fill_count", 32'(COUNT), 32'd4);
    check("fill_full", 32'(FULL), 32'd1);
    check("fill_ready", 32'(IN_READY), 32'd0);
    check("fill_err_sticky", 32'(ERR), 32'd1);

    OP_TYPE = 3'd0; IN_VALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("full_ready", 32'(IN_READY), 32'd0);
    end
    IN_VALID = 1'b0;
    check("full_writes", 32'(writes), 32'd5);

    @(posedge clk); #1 CLEAR = 1'b1;
    @(posedge clk); #1 CLEAR = 1'b0;
    @(negedge clk);
    check("clr2_count", 32'(COUNT), 32'd0);
    check("clr2_full", 32'(FULL), 32'd0);
    check("clr2_err", 32'(ERR), 32'd0);
    check("clr2_ready", 32'(IN_READY), 32'd1);

    // CLEAR together with IN_VALID: no accept
    @(posedge clk); #1;
    CLEAR = 1'b1; IN_VALID = 1'b1; OP_TYPE = 3'd1;
    @(negedge clk);
    check("clrv_ready", 32'(IN_READY), 32'd0);
    @(posedge clk); #1;
    CLEAR = 1'b0; IN_VALID = 1'b0;
    repeat (3) @(negedge clk);
    check("clrv_writes", 32'(writes), 32'd5);
    check("clrv_count", 32'(COUNT), 32'd0);
    check("clrv_ready2", 32'(IN_READY), 32'd1);

    // CLEAR in ENC aborts the word; restart at address 0
    send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 1'b1, 32'd0, 32'h0022_1820);
    wait_ready("pre_ready_low", 2);
    check("pre_count", 32'(COUNT), 32'd1);
    send(3'd1, 5'd7, 5'd6, 5'd0, 5'd0, 6'd0, 16'h0010, 1'b0, 32'd0, 32'd0);
    CLEAR = 1'b1;
    @(negedge clk);
    check("clre_we", 32'(IMEM_WE), 32'd0);
    check("clre_count", 32'(COUNT), 32'd1);
    @(posedge clk); #1 CLEAR = 1'b0;
    @(negedge clk);
    check("clre_we2", 32'(IMEM_WE), 32'd0);
    check("clre_count2", 32'(COUNT), 32'd0);
    check("clre_ready", 32'(IN_READY), 32'd1);
    repeat (2) @(negedge clk);
    send(3'd1, 5'd9, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 1'b1, 32'd0, 32'h8D28_0004);
    wait_ready("restart_ready_low", 2);
    check("restart_count", 32'(COUNT), 32'd1);

    // CLEAR in WR suppresses the strobe
    send(3'd2, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h0020, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1 CLEAR = 1'b1;
    @(negedge clk);
    check("clrw_we", 32'(IMEM_WE), 32'd0);
    check("clrw_count", 32'(COUNT), 32'd1);
    @(posedge clk); #1 CLEAR = 1'b0;
    @(negedge clk);
    check("clrw_count2", 32'(COUNT), 32'd0);
    check("clrw_ready", 32'(IN_READY), 32'd1);
    check("clrw_writes", 32'(writes), 32'd7);

    // reset in WR: strobe already active, then everything returns to reset values
    send(3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 1'b1, 32'd0, 32'h1022_FFFF);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("rstw_we", 32'(IMEM_WE), 32'd1);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rstw_count", 32'(COUNT), 32'd0);
    check("rstw_we2", 32'(IMEM_WE), 32'd0);
    check("rstw_addr", 32'(IMEM_ADDR), 32'd0);
    check("rstw_wdata", IMEM_WDATA, 32'd0);
    check("rstw_ready", 32'(IN_READY), 32'd1);
    check("total_writes", 32'(writes), 32'd8);
    check("queue_empty", 32'(q_addr.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
